// File: rtl/tf_pkg.sv
// Shared types and helpers for the temporal filter sequencer.
package tf_pkg;

  // Width of the x/y pixel coordinates carried on the stream.
  localparam int COORD_W = 11;

  // Frame-level operating modes of the filter.
  typedef enum logic [2:0] {
    IDLE,
    PASS,
    PRIME,
    RAMP,
    STEADY
  } tf_state_e;

  // Bits needed to carry a blend shift of 0..max_shift.
  function automatic int shift_w(input int max_shift);
    return (max_shift < 1) ? 1 : $clog2(max_shift + 1);
  endfunction

endpackage

// File: rtl/tf_delay_line.sv
// Valid + address shift register that delays history write-backs until the
// datapath result for the same pixel is ready. A flush drops everything in
// flight without disturbing the entry being presented this cycle.
module tf_delay_line #(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  // Shift valid and address one stage per cycle; reset/flush kill the valids.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      // NOTE: the address stages are reset as well (not just the valids) so
      // the write address port reads a defined 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q[0]  <= in_valid && !flush;
      addr_q[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1] && !flush;
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];

endmodule

// File: rtl/temporal_filter_ctrl.sv
// Temporal filter sequencer: follows the pixel stream position, addresses the
// history RAM in lockstep, schedules the per-frame blend weight and recovers
// from coordinate desynchronisation by falling back to IDLE and re-priming.
module temporal_filter_ctrl
  import tf_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int ADDR_W    = 19,
  parameter int RD_LAT    = 2,
  parameter int MAX_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            x_in,
  input  logic [COORD_W-1:0]            y_in,
  output logic                          hist_rd_en,
  output logic [ADDR_W-1:0]             hist_rd_addr,
  output logic                          hist_wr_en,
  output logic [ADDR_W-1:0]             hist_wr_addr,
  output logic [shift_w(MAX_SHIFT)-1:0] blend_shift,
  output logic                          bypass,
  output logic                          frame_done,
  output logic                          sync_err,
  output logic [15:0]                   frame_cnt
);

  localparam int SHIFT_W = shift_w(MAX_SHIFT);
  localparam int PIX_N   = IMG_W * IMG_H;

  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0]  A_LAST    = ADDR_W'(PIX_N - 1);
  localparam logic [SHIFT_W-1:0] SHIFT_ONE = SHIFT_W'(1);
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(MAX_SHIFT);

  // Registered state
  tf_state_e          state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [COORD_W-1:0] exp_x_q, exp_x_d;
  logic [COORD_W-1:0] exp_y_q, exp_y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               frame_done_q;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  // Per-cycle decode
  logic               frame_start;
  logic               sync_err_c;
  tf_state_e          eff_state;
  logic [SHIFT_W-1:0] eff_shift;
  logic [SHIFT_W-1:0] shift_inc;
  logic               px_ok;
  logic               strobe_ok;
  logic               last_pix;
  logic               wr_req;
  logic [ADDR_W-1:0]  pix_addr;

  // Frame-start detect and coordinate check against the expected position.
  always_comb begin
    frame_start = pix_valid && (x_in == '0) && (y_in == '0);
    sync_err_c  = 1'b0;
    // IDLE is not locked to the stream, so there is nothing to check there.
    if (pix_valid && (state_q != IDLE)) begin
      if (frame_start) begin
        sync_err_c = (exp_x_q != '0) || (exp_y_q != '0);
      end else begin
        sync_err_c = (x_in != exp_x_q) || (y_in != exp_y_q);
      end
    end
  end

  // Next-state and outputs. The mode for a frame is decided on its (0,0)
  // pixel and applies to that pixel already, hence the "effective" state.
  always_comb begin
    // NOTE: every variable gets a default up front so no path through the
    // case/if tree leaves one unassigned, which would infer a latch.
    eff_state   = state_q;
    eff_shift   = shift_q;
    shift_inc   = shift_q + SHIFT_ONE;
    state_d     = state_q;
    shift_d     = shift_q;
    exp_x_d     = exp_x_q;
    exp_y_d     = exp_y_q;
    addr_d      = addr_q;
    frame_cnt_d = frame_cnt_q;

    if (frame_start) begin
      // A mid-frame (0,0) has already dropped us to IDLE; IDLE then accepts it.
      case (sync_err_c ? IDLE : state_q)
        PRIME: begin
          if (en) begin
            eff_shift = SHIFT_ONE;
            eff_state = (SHIFT_ONE == SHIFT_MAX) ? STEADY : RAMP;
          end else begin
            eff_shift = '0;
            eff_state = PASS;
          end
        end
        RAMP: begin
          if (en) begin
            eff_shift = shift_inc;
            eff_state = (shift_inc == SHIFT_MAX) ? STEADY : RAMP;
          end else begin
            eff_shift = '0;
            eff_state = PASS;
          end
        end
        STEADY: begin
          eff_shift = en ? SHIFT_MAX : '0;
          eff_state = en ? STEADY : PASS;
        end
        default: begin
          eff_shift = '0;
          eff_state = en ? PRIME : PASS;
        end
      endcase
    end

    // A mismatch anywhere but on (0,0) loses the pixel outright.
    px_ok     = pix_valid && (eff_state != IDLE) && !(sync_err_c && !frame_start);
    strobe_ok = px_ok && !sync_err_c;
    pix_addr  = frame_start ? '0 : addr_q;
    last_pix  = px_ok && (x_in == X_LAST) && (y_in == Y_LAST);
    wr_req    = strobe_ok && (eff_state inside {PRIME, RAMP, STEADY});

    hist_rd_en   = strobe_ok && (eff_state inside {RAMP, STEADY});
    hist_rd_addr = pix_addr;
    bypass       = !(eff_state inside {RAMP, STEADY});
    blend_shift  = eff_shift;
    sync_err     = sync_err_c;

    if (sync_err_c && !frame_start) begin
      // History can no longer be trusted: wait for a clean frame start.
      state_d = IDLE;
      shift_d = '0;
      exp_x_d = '0;
      exp_y_d = '0;
      addr_d  = '0;
    end else begin
      state_d = eff_state;
      shift_d = eff_shift;
      if (px_ok) begin
        // Raster position and linear address advance together; no multiply.
        if (x_in == X_LAST) begin
          exp_x_d = '0;
          exp_y_d = (y_in == Y_LAST) ? '0 : y_in + COORD_W'(1);
        end else begin
          exp_x_d = x_in + COORD_W'(1);
          exp_y_d = y_in;
        end
        addr_d = (pix_addr == A_LAST) ? '0 : pix_addr + ADDR_W'(1);
      end
    end

    if (last_pix) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // State, position and frame bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      exp_x_q      <= '0;
      exp_y_q      <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      shift_q      <= shift_d;
      exp_x_q      <= exp_x_d;
      exp_y_q      <= exp_y_d;
      addr_q       <= addr_d;
      frame_done_q <= last_pix;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  // Write-back lines up with the datapath result RD_LAT+1 cycles later; a
  // sync error flushes whatever is still in flight.
  tf_delay_line #(
    .DEPTH  (RD_LAT + 1),
    .ADDR_W (ADDR_W)
  ) u_wr_dly (
    .clk       (clk),
    .rst       (rst),
    .flush     (sync_err_c),
    .in_valid  (wr_req),
    .in_addr   (pix_addr),
    .out_valid (hist_wr_en),
    .out_addr  (hist_wr_addr)
  );

endmodule
